// File: rtl/common_pkg.sv
// Shared types and defaults for the unit-clause scanner.
// Optional feature macro: UNIT_SCAN_ASSIGN_EN.
package common;

    localparam int DEF_NUM_CLAUSES = 64;
    localparam int DEF_MAX_LITS    = 4;
    localparam int DEF_VAR_W       = 5;
    localparam int DEF_LANES       = 4;

    typedef enum logic [1:0] {
        CL_SAT,
        CL_UNRES,
        CL_UNIT,
        CL_CONFLICT
    } clause_status_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_t;

    localparam logic [DEF_VAR_W:0] ZERO_LIT = '0;

endpackage

// File: rtl/clause_eval.sv
// Combinational single-clause evaluator: status and implied literal.
// UNIT_SCAN_ASSIGN_EN selects assignment-aware evaluation.
module clause_eval
    import common::*;
#(
    parameter  int MAX_LITS = DEF_MAX_LITS,
    parameter  int VAR_W    = DEF_VAR_W,
    localparam int LIT_W    = VAR_W + 1,
    localparam int LEN_W    = $clog2(MAX_LITS + 1),
    localparam int NUM_VARS = 2 ** VAR_W
) (
    input  logic [LEN_W-1:0]          len,
    input  logic [MAX_LITS*LIT_W-1:0] lits,
    input  logic [NUM_VARS-1:0]       assign_def,
    input  logic [NUM_VARS-1:0]       assign_val,
    output clause_status_t            status,
    output logic [LIT_W-1:0]          unit_lit
);

`ifdef UNIT_SCAN_ASSIGN_EN

    logic [LEN_W-1:0] n_open;
    logic             any_true;
    logic [LIT_W-1:0] lit;
    logic [VAR_W-1:0] v;
    logic             neg;

    always_comb begin
        n_open   = '0;
        any_true = 1'b0;
        unit_lit = LIT_W'(ZERO_LIT);
        lit      = '0;
        v        = '0;
        neg      = 1'b0;
        for (int i = 0; i < MAX_LITS; i++) begin
            lit = lits[i*LIT_W +: LIT_W];
            v   = lit[VAR_W-1:0];
            neg = lit[VAR_W];
            if (LEN_W'(i) < len) begin
                if (assign_def[v]) begin
                    if (assign_val[v] != neg)
                        any_true = 1'b1;
                end else begin
                    n_open   = n_open + LEN_W'(1);
                    unit_lit = lit;
                end
            end
        end
    end

    always_comb begin
        status = CL_UNRES;
        unique case (1'b1)
            any_true:
                status = CL_SAT;
            !any_true && n_open == '0:
                status = CL_CONFLICT;
            !any_true && n_open == LEN_W'(1):
                status = CL_UNIT;
            default:
                status = CL_UNRES;
        endcase
    end

`else

    // Without assignments only clause length can decide the status.
    logic unused_assign;
    assign unused_assign = ^{assign_def, assign_val, lits};

    assign unit_lit = lits[LIT_W-1:0];

    always_comb begin
        status = CL_UNRES;
        unique case (1'b1)
            len == '0:
                status = CL_CONFLICT;
            len == LEN_W'(1):
                status = CL_UNIT;
            default:
                status = CL_UNRES;
        endcase
    end

`endif

endmodule

// File: rtl/unit_clause_scan.sv
// Multi-lane scanner for the lowest unit or conflicting clause.
// UNIT_SCAN_ASSIGN_EN enables assignment-aware clause evaluation.
module unit_clause_scan
    import common::*;
#(
    parameter  int NUM_CLAUSES = DEF_NUM_CLAUSES,
    parameter  int MAX_LITS    = DEF_MAX_LITS,
    parameter  int VAR_W       = DEF_VAR_W,
    parameter  int LANES       = DEF_LANES,
    localparam int CI_W        = $clog2(NUM_CLAUSES),
    localparam int CNT_W       = CI_W + 1,
    localparam int LEN_W       = $clog2(MAX_LITS + 1),
    localparam int LIT_W       = VAR_W + 1,
    localparam int CL_W        = MAX_LITS * LIT_W,
    localparam int NUM_VARS    = 2 ** VAR_W,
    localparam int NUM_GROUPS  = NUM_CLAUSES / LANES,
    localparam int G_W         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        find,
    input  logic [CNT_W-1:0]            num_clauses,
    input  logic [NUM_CLAUSES*LEN_W-1:0] clause_len,
    input  logic [NUM_CLAUSES*CL_W-1:0] clause_lits,
    input  logic [NUM_VARS-1:0]         assign_def,
    input  logic [NUM_VARS-1:0]         assign_val,
    output logic                        busy,
    output logic                        ended,
    output logic                        found,
    output logic                        conflict,
    output logic [LIT_W-1:0]            lit_found,
    output logic [CI_W-1:0]             clause_idx
);

    scan_state_t       state;
    logic [G_W-1:0]    g_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  len_q  [NUM_CLAUSES];
    logic [CL_W-1:0]   lits_q [NUM_CLAUSES];
    logic [NUM_VARS-1:0] def_q;
    logic [NUM_VARS-1:0] val_q;

    logic [CNT_W-1:0]  cnt_clamp;
    logic [CNT_W-1:0]  base;
    logic              last_grp;

    assign cnt_clamp = (num_clauses > CNT_W'(NUM_CLAUSES))
                     ? CNT_W'(NUM_CLAUSES) : num_clauses;

    assign base     = CNT_W'(g_q) * CNT_W'(LANES);
    assign last_grp = (base + CNT_W'(LANES)) >= cnt_q;

    logic [CNT_W-1:0]  lane_n     [LANES];
    logic [LANES-1:0]  lane_valid;
    clause_status_t    lane_st    [LANES];
    logic [LIT_W-1:0]  lane_lit   [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [CI_W-1:0] ci;

        assign lane_n[l]     = base + CNT_W'(l);
        assign ci            = lane_n[l][CI_W-1:0];
        assign lane_valid[l] = lane_n[l] < cnt_q;

        clause_eval #(
            .MAX_LITS (MAX_LITS),
            .VAR_W    (VAR_W)
        ) u_eval (
            .len        (len_q[ci]),
            .lits       (lits_q[ci]),
            .assign_def (def_q),
            .assign_val (val_q),
            .status     (lane_st[l]),
            .unit_lit   (lane_lit[l])
        );
    end

    logic             hit;
    logic             hit_conf;
    logic [CI_W-1:0]  hit_idx;
    logic [LIT_W-1:0] hit_lit;

    // Walk high to low so the lowest hitting lane wins.
    always_comb begin
        hit      = 1'b0;
        hit_conf = 1'b0;
        hit_idx  = '0;
        hit_lit  = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_valid[l] &&
                (lane_st[l] == CL_UNIT ||
                 lane_st[l] == CL_CONFLICT)) begin
                hit      = 1'b1;
                hit_conf = (lane_st[l] == CL_CONFLICT);
                hit_idx  = lane_n[l][CI_W-1:0];
                hit_lit  = lane_lit[l];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            ended      <= 1'b0;
            found      <= 1'b0;
            conflict   <= 1'b0;
            lit_found  <= '0;
            clause_idx <= '0;
            g_q        <= '0;
            cnt_q      <= '0;
            def_q      <= '0;
            val_q      <= '0;
            for (int c = 0; c < NUM_CLAUSES; c++) begin
                len_q[c]  <= '0;
                lits_q[c] <= '0;
            end
        end else begin
            ended <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (find) begin
                        for (int c = 0; c < NUM_CLAUSES; c++) begin
                            len_q[c]  <= clause_len[c*LEN_W +: LEN_W];
                            lits_q[c] <= clause_lits[c*CL_W +: CL_W];
                        end
                        cnt_q      <= cnt_clamp;
                        def_q      <= assign_def;
                        val_q      <= assign_val;
                        found      <= 1'b0;
                        conflict   <= 1'b0;
                        lit_found  <= '0;
                        clause_idx <= '0;
                        g_q        <= '0;
                        busy       <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        clause_idx <= hit_idx;
                        conflict   <= hit_conf;
                        found      <= !hit_conf;
                        if (!hit_conf)
                            lit_found <= hit_lit;
                        state <= DONE;
                    end else if (last_grp) begin
                        state <= DONE;
                    end else begin
                        g_q <= g_q + G_W'(1);
                    end
                end
                DONE: begin
                    ended <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unit_clause_scan.sv
// Randomized and directed bench for unit_clause_scan.
// Reference model walks the clause list clause by clause.
module tb_unit_clause_scan;

    localparam int NC = 64;
    localparam int ML = 4;
    localparam int VW = 5;
    localparam int LN = 4;
    localparam int NV = 32;
    localparam int LW = 3;
    localparam int TW = VW + 1;

    logic               clock;
    logic               reset;
    logic               find;
    logic [6:0]         num_clauses;
    logic [NC*LW-1:0]   clause_len;
    logic [NC*ML*TW-1:0] clause_lits;
    logic [NV-1:0]      assign_def;
    logic [NV-1:0]      assign_val;
    logic               busy;
    logic               ended;
    logic               found;
    logic               conflict;
    logic [TW-1:0]      lit_found;
    logic [5:0]         clause_idx;

    unit_clause_scan dut (
        .clock       (clock),
        .reset       (reset),
        .find        (find),
        .num_clauses (num_clauses),
        .clause_len  (clause_len),
        .clause_lits (clause_lits),
        .assign_def  (assign_def),
        .assign_val  (assign_val),
        .busy        (busy),
        .ended       (ended),
        .found       (found),
        .conflict    (conflict),
        .lit_found   (lit_found),
        .clause_idx  (clause_idx)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int            n_tests;
    int            n_fail;
    int            m_len [NC];
    logic [TW-1:0] m_lit [NC][ML];
    bit            m_def [NV];
    bit            m_val [NV];
    int            m_cnt;

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    // 0 sat, 1 unresolved, 2 unit, 3 conflict
    function automatic int classify(int c,
                                    output logic [TW-1:0] ul);
        int  open;
        bit  tru;
        open = 0;
        tru  = 0;
        ul   = '0;
`ifdef UNIT_SCAN_ASSIGN_EN
        for (int s = 0; s < m_len[c]; s++) begin
            int v;
            v = int'(m_lit[c][s][VW-1:0]);
            if (m_def[v]) begin
                if (m_val[v] != m_lit[c][s][VW]) tru = 1;
            end else begin
                open++;
                ul = m_lit[c][s];
            end
        end
        if (tru) return 0;
        if (open == 0) return 3;
        if (open == 1) return 2;
        return 1;
`else
        ul = m_lit[c][0];
        if (m_len[c] == 0) return 3;
        if (m_len[c] == 1) return 2;
        return 1;
`endif
    endfunction

    function automatic void model(output bit ef, output bit ec,
                                  output logic [TW-1:0] el,
                                  output int ei, output int eg);
        int eff;
        eff = (m_cnt > NC) ? NC : m_cnt;
        ef  = 0;
        ec  = 0;
        el  = '0;
        ei  = -1;
        eg  = (eff == 0) ? 1 : (eff + LN - 1) / LN;
        for (int c = 0; c < eff; c++) begin
            logic [TW-1:0] ul;
            int st;
            st = classify(c, ul);
            if (st >= 2) begin
                ef = (st == 2);
                ec = (st == 3);
                el = ul;
                ei = c;
                eg = c / LN + 1;
                return;
            end
        end
    endfunction

    task automatic pack();
        num_clauses = 7'(m_cnt);
        for (int c = 0; c < NC; c++) begin
            clause_len[c*LW +: LW] = LW'(m_len[c]);
            for (int s = 0; s < ML; s++)
                clause_lits[(c*ML+s)*TW +: TW] = m_lit[c][s];
        end
        for (int v = 0; v < NV; v++) begin
            assign_def[v] = m_def[v];
            assign_val[v] = m_val[v];
        end
    endtask

    task automatic scramble();
        num_clauses = 7'($urandom);
        for (int i = 0; i < NC*LW; i += 32)
            clause_len[i +: 32] = $urandom;
        for (int i = 0; i < NC*ML*TW; i += 32)
            clause_lits[i +: 32] = $urandom;
        assign_def = $urandom;
        assign_val = $urandom;
    endtask

    task automatic fill_sat(int cnt);
        m_cnt = cnt;
        for (int v = 0; v < NV; v++) begin
            m_def[v] = 0;
            m_val[v] = 0;
        end
        m_def[0] = 1;
        m_val[0] = 1;
        for (int c = 0; c < NC; c++) begin
            m_len[c] = 2;
            m_lit[c][0] = 6'd0;
            m_lit[c][1] = 6'd1;
            m_lit[c][2] = 6'd2;
            m_lit[c][3] = 6'd3;
        end
    endtask

    task automatic fill_rand();
        m_cnt = $urandom_range(0, 70);
        for (int v = 0; v < NV; v++) begin
            m_def[v] = ($urandom % 10) < 7;
            m_val[v] = 1'($urandom);
        end
        for (int c = 0; c < NC; c++) begin
            if ($urandom % 30 == 0)
                m_len[c] = $urandom_range(0, 1);
            else
                m_len[c] = $urandom_range(2, 4);
            for (int s = 0; s < ML; s++)
                m_lit[c][s] = TW'($urandom);
        end
    endtask

    task automatic run(string tag, bit noise);
        bit            ef;
        bit            ec;
        logic [TW-1:0] el;
        int            ei;
        int            eg;
        int            k;
        int            extra;
        bit            got_end;
        model(ef, ec, el, ei, eg);
        pack();
        @(negedge clock);
        find = 1'b1;
        @(posedge clock);
        @(negedge clock);
        find = 1'b0;
        scramble();
        check({tag, ".busy"}, 32'(busy), 1);
        k = 0;
        got_end = 0;
        while (k < 100 && !got_end) begin
            find = noise ? 1'($urandom) : 1'b0;
            @(posedge clock);
            @(negedge clock);
            k++;
            if (ended) got_end = 1;
        end
        find = 1'b0;
        check({tag, ".ended"}, 32'(got_end), 1);
        check({tag, ".latency"}, 32'(k), 32'(eg + 1));
        check({tag, ".busy_off"}, 32'(busy), 0);
        check({tag, ".found"}, 32'(found), 32'(ef));
        check({tag, ".conflict"}, 32'(conflict), 32'(ec));
        if (ef)
            check({tag, ".lit"}, 32'(lit_found), 32'(el));
        if (ei >= 0)
            check({tag, ".idx"}, 32'(clause_idx), 32'(ei));
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (ended || busy) extra++;
        end
        check({tag, ".quiet"}, 32'(extra), 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        find    = 1'b0;
        fill_sat(0);
        pack();
        repeat (3) @(negedge clock);
        check("rst.busy", 32'(busy), 0);
        check("rst.ended", 32'(ended), 0);
        check("rst.found", 32'(found), 0);
        check("rst.conflict", 32'(conflict), 0);
        check("rst.lit", 32'(lit_found), 0);
        check("rst.idx", 32'(clause_idx), 0);
        reset = 1'b1;
        @(negedge clock);

        // Unit in group 0 at clause 2.
        fill_sat(3);
        m_len[2] = 1;
        m_lit[2][0] = {1'b0, 5'd5};
        run("unit2", 1'b0);

        // Deepest clause of a full formula.
        fill_sat(64);
        m_len[61] = 2;
        m_lit[61][0] = {1'b1, 5'd3};
        m_lit[61][1] = {1'b0, 5'd7};
        m_def[7] = 1;
        m_val[7] = 0;
        for (int c = 0; c < 61; c++) m_lit[c][1] = 6'd0;
        for (int c = 62; c < NC; c++) m_lit[c][1] = 6'd0;
        run("unit61", 1'b0);

        // Conflict at 0 beats unit at 1.
        fill_sat(64);
        m_len[0] = 1;
        m_lit[0][0] = {1'b1, 5'd2};
        m_def[2] = 1;
        m_val[2] = 1;
        m_len[1] = 1;
        m_lit[1][0] = {1'b0, 5'd9};
        run("prio", 1'b0);

        fill_sat(0);
        run("empty", 1'b1);
        fill_sat(64);
        run("allsat", 1'b1);

        // Count above capacity clamps; last clause empty.
        fill_sat(100);
        m_len[63] = 0;
        run("clamp", 1'b0);

        fill_sat(64);
        m_len[4] = 1;
        m_lit[4][0] = {1'b0, 5'd6};
        m_def[6] = 1;
        m_val[6] = 1;
        run("len1_true", 1'b0);

        // Reset in the middle of a long scan.
        fill_sat(64);
        pack();
        @(negedge clock);
        find = 1'b1;
        @(posedge clock);
        @(negedge clock);
        find = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst.busy", 32'(busy), 0);
        check("midrst.ended", 32'(ended), 0);
        check("midrst.found", 32'(found), 0);
        check("midrst.conflict", 32'(conflict), 0);
        @(negedge clock);
        reset = 1'b1;
        fill_sat(3);
        m_len[2] = 1;
        m_lit[2][0] = {1'b0, 5'd5};
        run("restart", 1'b0);

        // find held high re-accepts right after DONE.
        begin
            int  k;
            bit  seen;
            pack();
            @(negedge clock);
            find = 1'b1;
            k = 0;
            seen = 0;
            while (k < 40 && !seen) begin
                @(posedge clock);
                @(negedge clock);
                k++;
                if (ended) seen = 1;
            end
            check("b2b.first", 32'(seen), 1);
            @(posedge clock);
            @(negedge clock);
            find = 1'b0;
            check("b2b.reaccept", 32'(busy), 1);
            k = 0;
            seen = 0;
            while (k < 40 && !seen) begin
                @(posedge clock);
                @(negedge clock);
                k++;
                if (ended) seen = 1;
            end
            check("b2b.second", 32'(seen), 1);
            check("b2b.lat", 32'(k), 2);
        end

        for (int t = 0; t < 40; t++) begin
            fill_rand();
            run($sformatf("rand%0d", t), 1'(t % 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/unit_clause_scan.md
# unit_clause_scan

Parametrised successor to the single-lane unit-clause finder in the SAT solver's propagation loop. Scans a latched clause set LANES clauses per cycle under a partial variable assignment. Stops at the lowest-index clause that is unit (exactly one unassigned literal, none true) or conflicting (all literals false, or empty). Reports that clause's index and, for a unit, the implied literal. Feeds the decision/propagation controller.

## Interface
- NUM_CLAUSES, 64: clause slots in the formula image.
- MAX_LITS, 4: literal slots per clause.
- VAR_W, 5: variable index width; NUM_VARS = 2**VAR_W.
- LANES, 4: clauses evaluated per cycle; must divide NUM_CLAUSES.
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- find  in  1  start request; sampled only in IDLE.
- num_clauses  in  $clog2(NUM_CLAUSES)+1  live clause count; values above NUM_CLAUSES clamp to NUM_CLAUSES.
- clause_len  in  NUM_CLAUSES*$clog2(MAX_LITS+1)  per-clause literal count.
- clause_lits  in  NUM_CLAUSES*MAX_LITS*(VAR_W+1)  literal {neg, var} per slot.
- assign_def  in  NUM_VARS  variable assigned.
- assign_val  in  NUM_VARS  assigned value.
- busy  out  1  high from accepted find until ended.
- ended  out  1  one-cycle completion pulse.
- found  out  1  unit clause reported.
- conflict  out  1  conflicting clause reported.
- lit_found  out  VAR_W+1  implied literal; valid when found.
- clause_idx  out  $clog2(NUM_CLAUSES)  index of reported clause.

## Operation
- FSM states IDLE, SCAN, DONE.
- IDLE + find=1: latch all formula/assignment inputs, clear found/conflict, group counter g=0, go to SCAN.
- SCAN evaluates clauses g*LANES .. g*LANES+LANES-1. Lanes at index >= clamped num_clauses are invalid.
- Literal true iff assign_def[var] && (assign_val[var] != neg). Literal false iff assign_def[var] && (assign_val[var] == neg).
- Literal slots >= clause_len are ignored.
- Per-lane status: SAT if any literal true; else CONFLICT if zero unassigned literals (includes len 0); else UNIT if exactly one unassigned literal; else UNRES.
- Lowest-index valid lane with UNIT or CONFLICT wins:
  - Latch clause_idx.
  - Set conflict=1, or found=1 with lit_found = the unassigned literal.
  - Go to DONE.
- No hit in group and group is last (g*LANES+LANES >= clamped count, or count 0): go to DONE with found=conflict=0. Otherwise g++.
- DONE: ended=1, go to IDLE.
- found, conflict, lit_found, clause_idx hold until the next accepted find.
- find while busy: ignored.
- Inputs may change after the accept cycle without effect.

## Timing
- Reset values (all outputs and state): busy, ended, found, conflict = 0; lit_found, clause_idx = 0; FSM in IDLE.
- find sampled high at edge t: busy=1 from t+1. A scan of G groups (G >= 1) gives ended=1 in the cycle after edge t+G+1. busy drops with ended.
- Best case (hit in group 0, or count 0): ended pulse 2 cycles after find.
- Worst case: NUM_CLAUSES/LANES + 1 cycles.
- Back-to-back: find held high re-accepts in the IDLE cycle following DONE.
- Reset asserted mid-scan: immediate return to reset values; partial result discarded.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- UNIT_SCAN_ASSIGN_EN defined: assignment-aware evaluation as above.
- Not defined: assign_def/assign_val ports present but ignored (all literals treated unassigned).
  - Clause is UNIT iff clause_len==1 (lit_found = slot 0).
  - Clause is CONFLICT iff clause_len==0.
  - Scan, priority and timing unchanged.

## Structure
- Package common holds:
  - default constants NUM_CLAUSES/MAX_LITS/VAR_W;
  - clause_status_t enum {CL_SAT, CL_UNRES, CL_UNIT, CL_CONFLICT};
  - scan_state_t enum;
  - ZERO_LIT.
- Sub-module clause_eval: combinational single-clause evaluator returning status and unit literal. Instantiated LANES times; priority pick and FSM stay in unit_clause_scan.

## Test plan
- Reset mid-scan: reset low in SCAN -> busy=0, ended=0, found=0, FSM IDLE, next find restarts cleanly.
- num_clauses=3, clause 2 = {x5}, x5 unassigned, others SAT, LANES=4 -> ended 2 cycles after find, found=1, lit_found={0,5}, clause_idx=2.
- num_clauses=64, only clause 61 = {¬x3, x7} with x7=0 assigned -> ended after 16+1 cycles, found=1, lit_found={1,3}, clause_idx=61.
- Clause 1 UNIT, clause 0 CONFLICT (x2=1, clause {¬x2}) -> conflict=1, found=0, clause_idx=0.
- num_clauses=0, and separately all clauses SAT -> ended pulse, found=conflict=0; find pulsed while busy produces no second ended.
- Macro undefined: clause 4 len 1 with its var assigned true -> found=1, clause_idx=4 (assignment ignored).
